// File: rtl/alu_cc_stage_if.sv
// Handshake and payload bundle between the add/sub stage, the CC stage and
// the memory stage. The "slave" view belongs to the CC stage itself; the
// "master" view is the mirror used by whatever drives and consumes it.
interface alu_cc_stage_if #(
  parameter int WIDTH = 64
);
  // upstream side: add/sub result offered to the CC stage
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_icode;
  logic [3:0]       in_ifun;
  logic [WIDTH-1:0] in_val_e;
  logic             in_ovf;

  // downstream side: registered payload offered to the memory stage
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_icode;
  logic [WIDTH-1:0] out_val_e;
  logic             out_cnd;

  modport slave (
    input  in_valid, in_icode, in_ifun, in_val_e, in_ovf, out_ready,
    output in_ready, out_valid, out_icode, out_val_e, out_cnd
  );

  modport master (
    output in_valid, in_icode, in_ifun, in_val_e, in_ovf, out_ready,
    input  in_ready, out_valid, out_icode, out_val_e, out_cnd
  );
endinterface

// File: rtl/alu_cc_stage.sv
// Y86 execute back-end: owns the condition-code register (ZF/SF/OF),
// evaluates the branch/cmov condition against the CC contents as they were
// before the instruction, and registers the result for the memory stage
// behind a single-entry valid/ready pipeline register.
module alu_cc_stage #(
  parameter int WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_cc_stage_if.slave bus,
  output logic          zf,
  output logic          sf,
  output logic          of
);

  localparam logic [3:0] ICODE_OPQ = 4'h6;

  logic             out_valid_reg;
  logic [3:0]       out_icode_reg;
  logic [WIDTH-1:0] out_val_e_reg;
  logic             out_cnd_reg;
  logic             zf_reg;
  logic             sf_reg;
  logic             of_reg;

  logic             in_ready;
  logic             accept;
  logic             cc_write;
  logic             cnd_next;
  logic             lt;

  // The slot is free when empty or when its occupant leaves this cycle;
  // deliberately independent of in_valid so upstream can rely on it.
  assign in_ready = !out_valid_reg || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !flush;
  assign cc_write = accept && (bus.in_icode == ICODE_OPQ);

  // Signed less-than as seen by the current (pre-update) flags.
  assign lt = sf_reg ^ of_reg;

  // Condition evaluation from the CC contents before this instruction writes them.
  always_comb begin
    cnd_next = 1'b0;
    case (bus.in_ifun)
      4'd0:    cnd_next = 1'b1;
      4'd1:    cnd_next = lt || zf_reg;
      4'd2:    cnd_next = lt;
      4'd3:    cnd_next = zf_reg;
      4'd4:    cnd_next = !zf_reg;
      4'd5:    cnd_next = !lt;
      4'd6:    cnd_next = !lt && !zf_reg;
      default: cnd_next = 1'b0;
    endcase
  end

  // Output register: load on accept, hold while stalled, drain or squash otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_icode_reg <= 4'h0;
      out_val_e_reg <= '0;
      out_cnd_reg   <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_icode_reg <= bus.in_icode;
      out_val_e_reg <= bus.in_val_e;
      out_cnd_reg   <= cnd_next;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Condition-code register: only an accepted OPq writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_reg <= 1'b1;
      sf_reg <= 1'b0;
      of_reg <= 1'b0;
    end else if (cc_write) begin
      zf_reg <= (bus.in_val_e == '0);
      sf_reg <= bus.in_val_e[WIDTH-1];
      of_reg <= bus.in_ovf;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_icode = out_icode_reg;
  assign bus.out_val_e = out_val_e_reg;
  assign bus.out_cnd   = out_cnd_reg;
  assign zf            = zf_reg;
  assign sf            = sf_reg;
  assign of            = of_reg;

endmodule

// File: doc/alu_cc_stage.md
ALU_CC_STAGE -- requirements
Module: alu_cc_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width of val_e; CC and condition logic use bit WIDTH-1 as sign.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream subtractor/adder result valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have port in_icode  input  4  Y86 icode of the instruction.
REQ-007 SHALL have port in_ifun  input  4  Y86 ifun (ALU op or condition code).
REQ-008 SHALL have port in_val_e  input  WIDTH  ALU result from the add/sub stage.
REQ-009 SHALL have port in_ovf  input  1  signed-overflow flag from the add/sub stage.
REQ-010 SHALL have port flush  input  1  synchronous squash of held and incoming instruction.
REQ-011 SHALL have port out_valid  output  1  registered payload valid.
REQ-012 SHALL have port out_ready  input  1  downstream (memory stage) accepts.
REQ-013 SHALL have ports out_icode (4), out_val_e (WIDTH), out_cnd (1), outputs, registered payload.
REQ-014 SHALL have ports zf, sf, of  output  1 each  current condition-code register contents.

Function
REQ-015 Accept SHALL occur on a rising edge with in_valid=1, in_ready=1, flush=0.
REQ-016 in_ready SHALL equal (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-017 On accept, out_icode/out_val_e/out_cnd SHALL load and out_valid SHALL be 1 the next cycle (latency 1).
REQ-018 If out_valid=1 and out_ready=0, payload SHALL hold stable; no accept.
REQ-019 If out_valid=1, out_ready=1 and no accept, out_valid SHALL go 0 next cycle.
REQ-020 Back-to-back accept with out_ready=1 SHALL sustain one instruction per cycle.
REQ-021 CC SHALL update only on accept with in_icode==4'h6 (OPq): zf=(in_val_e==0), sf=in_val_e[WIDTH-1], of=in_ovf.
REQ-022 No other icode SHALL modify CC.
REQ-023 out_cnd SHALL be computed from CC contents before any update by the same accepted instruction.
REQ-024 out_cnd by in_ifun: 0 ->1; 1 le ->(sf^of)|zf; 2 l ->sf^of; 3 e ->zf; 4 ne ->!zf; 5 ge ->!(sf^of); 6 g ->!(sf^of)&!zf; 7-15 ->0.
REQ-025 out_cnd SHALL be evaluated for every accepted icode; consumers ignore it when irrelevant.
REQ-026 flush=1 SHALL clear out_valid next cycle, block accept and block CC update that cycle, irrespective of out_ready.
REQ-027 flush SHALL not alter CC contents already written.
REQ-028 Two OPq accepted on consecutive cycles: second's out_cnd SHALL use CC written by the first.
REQ-029 in_val_e, in_icode, in_ifun, in_ovf SHALL be ignored when no accept occurs.

Reset
REQ-030 rst_n=0 SHALL immediately force out_valid=0, out_icode=0, out_val_e=0, out_cnd=0.
REQ-031 rst_n=0 SHALL immediately force zf=1, sf=0, of=0.
REQ-032 in_ready SHALL be 1 during and after reset (out_valid=0).
REQ-033 Reset asserted mid-stall SHALL drop held payload; no accept occurs on the edge of deassertion unless rst_n was already 1 at that edge.

Verification
REQ-034 Reset then OPq in_val_e=0, in_ovf=0 -> next cycle out_valid=1, zf=1, sf=0, of=0, out_val_e=0.
REQ-035 OPq in_val_e=64'h8000_0000_0000_0000, in_ovf=1, then jXX ifun=2 (l) -> CC sf=1, of=1; jXX out_cnd=0; ifun=5 (ge) -> out_cnd=1.
REQ-036 OPq in_val_e=5 with in_ifun=3 -> out_cnd uses old CC (zf=1 after reset) =1; afterward zf=0.
REQ-037 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, payload unchanged, CC unchanged despite in_valid=1 OPq in_val_e=0.
REQ-038 flush=1 concurrent with in_valid=1 OPq in_val_e=7 -> out_valid=0 next cycle, zf unchanged.
REQ-039 Stream of 8 OPq with out_ready=1 -> 8 consecutive out_valid cycles, each out_val_e matching input order.
